// File: rtl/register_bank_pkg.sv
// rtl/register_bank_pkg.sv - shared op codes and sizing helper for the register bank
package register_bank_pkg;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    LOAD = 3'd1,
    CLR  = 3'd2,
    INC  = 3'd3,
    DEC  = 3'd4,
    SHL  = 3'd5,
    SHR  = 3'd6,
    RSVD = 3'd7
  } reg_op_e;

  // Select width for n registers; a single register still needs one select bit
  function automatic int addr_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/reg_op_unit.sv
// rtl/reg_op_unit.sv - combinational next-value and flag computation for one register
module reg_op_unit
  import register_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  reg_op_e          op,
  input  logic [WIDTH-1:0] cur_value,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] nxt_value,
  output logic             nxt_carry,
  output logic             nxt_zero,
  output logic             valid
);

  // Decode the op; valid is low for NOP and the reserved code so flags hold
  always_comb begin
    nxt_value = cur_value;
    nxt_carry = 1'b0;
    valid     = 1'b1;
    case (op)
      LOAD: nxt_value = bus_in;
      CLR:  nxt_value = '0;
      INC: begin
        nxt_value = cur_value + WIDTH'(1);
        nxt_carry = &cur_value;
      end
      DEC: begin
        nxt_value = cur_value - WIDTH'(1);
        nxt_carry = ~|cur_value;
      end
      SHL: begin
        nxt_value = {cur_value[WIDTH-2:0], 1'b0};
        nxt_carry = cur_value[WIDTH-1];
      end
      SHR: begin
        nxt_value = {1'b0, cur_value[WIDTH-1:1]};
        nxt_carry = cur_value[0];
      end
      default: valid = 1'b0;
    endcase
    nxt_zero = ~|nxt_value;
  end

endmodule

// File: rtl/register_bank.sv
// rtl/register_bank.sv - bank of bus registers with single-cycle ops and registered flags
module register_bank
  import register_bank_pkg::*;
#(
  parameter int               WIDTH           = 8,
  parameter int               NUM_REGS        = 4,
  parameter logic [WIDTH-1:0] BUS_OUTPUT_MASK = {WIDTH{1'b1}},
  localparam int              ADDR_W          = addr_w(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  reg_op_e                   op,
  input  logic [ADDR_W-1:0]         wr_sel,
  input  logic [ADDR_W-1:0]         rd_sel,
  input  logic                      out_en,
  input  logic [WIDTH-1:0]          bus_in,
  output logic [WIDTH-1:0]          bus_out,
  output logic [NUM_REGS*WIDTH-1:0] values,
  output logic                      carry,
  output logic                      zero
);

  logic [WIDTH-1:0] regs [NUM_REGS];

  logic [WIDTH-1:0] wr_value;
  logic             wr_hit;
  logic [WIDTH-1:0] rd_value;
  logic             rd_hit;

  logic [WIDTH-1:0] nxt_value;
  logic             nxt_carry;
  logic             nxt_zero;
  logic             op_valid;

  // Select the target register by comparison so out-of-range selects simply miss
  always_comb begin
    wr_value = '0;
    wr_hit   = 1'b0;
    rd_value = '0;
    rd_hit   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_sel == ADDR_W'(i)) begin
        wr_value = regs[i];
        wr_hit   = 1'b1;
      end
      if (rd_sel == ADDR_W'(i)) begin
        rd_value = regs[i];
        rd_hit   = 1'b1;
      end
    end
  end

  reg_op_unit #(
    .WIDTH(WIDTH)
  ) u_op (
    .op       (op),
    .cur_value(wr_value),
    .bus_in   (bus_in),
    .nxt_value(nxt_value),
    .nxt_carry(nxt_carry),
    .nxt_zero (nxt_zero),
    .valid    (op_valid)
  );

  // Storage and flags: reset wins, otherwise only an executed op on a real register commits
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      carry <= 1'b0;
      zero  <= 1'b0;
    end else if (op_valid && wr_hit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel == ADDR_W'(i)) begin
          regs[i] <= nxt_value;
        end
      end
      carry <= nxt_carry;
      zero  <= nxt_zero;
    end
  end

  // Read path reflects stored state only, so looping bus_out back to bus_in is safe
  always_comb begin
    bus_out = (out_en && rd_hit) ? (rd_value & BUS_OUTPUT_MASK) : '0;
  end

  // Flatten the array for observation by the control unit
  always_comb begin
    values = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      values[i*WIDTH +: WIDTH] = regs[i];
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// tb/tb_register_bank.sv - directed self-checking bench for register_bank
module tb_register_bank;
  import register_bank_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  reg_op_e    op;
  logic [1:0] wr_sel;
  logic [1:0] rd_sel;
  logic       out_en;
  logic [7:0] bus_in;

  logic [7:0]  bus_out,  bus_out_m,  bus_out_3;
  logic [31:0] values,   values_m;
  logic [23:0] values_3;
  logic        carry,    carry_m,    carry_3;
  logic        zero,     zero_m,     zero_3;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  register_bank #(.WIDTH(8), .NUM_REGS(4)) dut (
    .clk(clk), .rst(rst), .op(op), .wr_sel(wr_sel), .rd_sel(rd_sel),
    .out_en(out_en), .bus_in(bus_in), .bus_out(bus_out), .values(values),
    .carry(carry), .zero(zero)
  );

  register_bank #(.WIDTH(8), .NUM_REGS(4), .BUS_OUTPUT_MASK(8'h0F)) dut_m (
    .clk(clk), .rst(rst), .op(op), .wr_sel(wr_sel), .rd_sel(rd_sel),
    .out_en(out_en), .bus_in(bus_in), .bus_out(bus_out_m), .values(values_m),
    .carry(carry_m), .zero(zero_m)
  );

  register_bank #(.WIDTH(8), .NUM_REGS(3)) dut3 (
    .clk(clk), .rst(rst), .op(op), .wr_sel(wr_sel), .rd_sel(rd_sel),
    .out_en(out_en), .bus_in(bus_in), .bus_out(bus_out_3), .values(values_3),
    .carry(carry_3), .zero(zero_3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input reg_op_e o, input logic [1:0] ws,
                       input logic [1:0] rs, input logic [7:0] d);
    rst = r; op = o; wr_sel = ws; rd_sel = rs; bus_in = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_en = 1'b1;
    drive(1'b1, LOAD, 2'd2, 2'd0, 8'hAA);
    tick();
    check("rst_values", values, 32'h0);
    check("rst_carry", {31'b0, carry}, 32'h0);
    check("rst_zero", {31'b0, zero}, 32'h0);
    check("rst_bus_out", {24'b0, bus_out}, 32'h0);
    check("rst_values3", {8'b0, values_3}, 32'h0);

    drive(1'b0, LOAD, 2'd2, 2'd2, 8'h3C);
    tick();
    check("load_values", values, 32'h003C_0000);
    check("load_bus_out", {24'b0, bus_out}, 32'h3C);
    check("load_zero", {31'b0, zero}, 32'h0);
    check("mask_bus_out", {24'b0, bus_out_m}, 32'h0C);
    check("mask_values", values_m, 32'h003C_0000);
    out_en = 1'b0;
    #1;
    check("out_en_low", {24'b0, bus_out}, 32'h0);
    out_en = 1'b1;

    drive(1'b0, LOAD, 2'd1, 2'd1, 8'hFF);
    tick();
    check("load_ff", values, 32'h003C_FF00);
    drive(1'b0, INC, 2'd1, 2'd1, 8'h00);
    tick();
    check("inc_wrap_val", values, 32'h003C_0000);
    check("inc_wrap_cz", {30'b0, carry, zero}, 32'h3);
    drive(1'b0, DEC, 2'd1, 2'd1, 8'h00);
    tick();
    check("dec_wrap_val", values, 32'h003C_FF00);
    check("dec_wrap_cz", {30'b0, carry, zero}, 32'h2);
    tick();
    check("dec_val", values, 32'h003C_FE00);
    check("dec_cz", {30'b0, carry, zero}, 32'h0);

    drive(1'b0, LOAD, 2'd0, 2'd0, 8'h81);
    tick();
    check("load_81", values, 32'h003C_FE81);
    drive(1'b0, SHL, 2'd0, 2'd0, 8'h00);
    tick();
    check("shl_val", {24'b0, bus_out}, 32'h02);
    check("shl_cz", {30'b0, carry, zero}, 32'h2);
    drive(1'b0, SHR, 2'd0, 2'd0, 8'h00);
    tick();
    check("shr1_val", {24'b0, bus_out}, 32'h01);
    check("shr1_cz", {30'b0, carry, zero}, 32'h0);
    tick();
    check("shr2_val", values, 32'h003C_FE00);
    check("shr2_cz", {30'b0, carry, zero}, 32'h3);

    for (int i = 0; i < 5; i++) begin
      drive(1'b0, (i == 2) ? RSVD : NOP, 2'(i), 2'd0, 8'h55);
      tick();
    end
    check("nop_hold_val", values, 32'h003C_FE00);
    check("nop_hold_cz", {30'b0, carry, zero}, 32'h3);

    drive(1'b0, LOAD, 2'd3, 2'd3, 8'h10);
    tick();
    check("load_r3", values, 32'h103C_FE00);
    check("load_r3_cz", {30'b0, carry, zero}, 32'h0);
    check("oor_values3", {8'b0, values_3}, 32'h003C_FE00);
    check("oor_flags3", {30'b0, carry_3, zero_3}, 32'h3);
    check("oor_bus_out3", {24'b0, bus_out_3}, 32'h0);

    drive(1'b0, INC, 2'd3, 2'd3, 8'h00);
    #1;
    check("same_cycle_old", {24'b0, bus_out}, 32'h10);
    tick();
    check("same_cycle_new", {24'b0, bus_out}, 32'h11);
    check("inc_r3_vals", values, 32'h113C_FE00);

    drive(1'b0, CLR, 2'd2, 2'd2, 8'h00);
    tick();
    check("clr_val", values, 32'h1100_FE00);
    check("clr_cz", {30'b0, carry, zero}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, NOP, 2'd1, 2'd1, 8'h00);
      tick();
    end
    check("nop5_cz", {30'b0, carry, zero}, 32'h1);

    drive(1'b0, INC, 2'd0, 2'd3, 8'h00);
    tick();
    check("pre_rst_cz", {30'b0, carry, zero}, 32'h0);
    drive(1'b1, INC, 2'd1, 2'd1, 8'h00);
    tick();
    check("mid_rst_values", values, 32'h0);
    check("mid_rst_values3", {8'b0, values_3}, 32'h0);
    check("mid_rst_cz", {30'b0, carry, zero}, 32'h0);
    drive(1'b0, NOP, 2'd1, 2'd1, 8'h00);
    tick();
    check("post_rst_values", values, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
